// File: rtl/mux_scan_ctrl.sv
// Select-line sequencer and sampler for a 4:1 mux: walks {s0,s1} through all four
// channels, samples x after DWELL cycles on each, and hands off a 4-bit snapshot.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_x,
    output logic       s0,
    output logic       s1,
    output logic [3:0] snap,
    output logic       snap_valid,
    input  logic       snap_ready,
    output logic       busy
);

    if (DWELL < 1 || DWELL > 255) begin : g_dwell_check
        $error("mux_scan_ctrl: DWELL must be in 1..255");
    end

    localparam logic [7:0] CntLast = 8'(DWELL - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e     state;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic [2:0] shadow;
    logic [3:0] shadow_upd;

    // Shadow with the current sample merged in; on ch3 this is the full snapshot.
    always_comb begin
        shadow_upd     = {1'b0, shadow};
        shadow_upd[ch] = mux_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            ch         <= 2'd0;
            cnt        <= 8'd0;
            shadow     <= 3'b000;
            s0         <= 1'b0;
            s1         <= 1'b0;
            snap       <= 4'b0000;
            snap_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StScan;
                        ch       <= 2'd0;
                        cnt      <= 8'd0;
                        shadow   <= 3'b000;
                        {s0, s1} <= 2'b00;
                        busy     <= 1'b1;
                    end
                end
                StScan: begin
                    if (cnt == CntLast) begin
                        cnt <= 8'd0;
                        if (ch == 2'd3) begin
                            state      <= StDone;
                            ch         <= 2'd0;
                            snap       <= shadow_upd;
                            snap_valid <= 1'b1;
                            {s0, s1}   <= 2'b00;
                        end else begin
                            shadow   <= shadow_upd[2:0];
                            ch       <= ch + 2'd1;
                            {s0, s1} <= ch + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StDone: begin
                    if (snap_ready) begin
                        snap_valid <= 1'b0;
                        if (continuous) begin
                            // Rescan straight away; busy stays high.
                            state  <= StScan;
                            ch     <= 2'd0;
                            cnt    <= 8'd0;
                            shadow <= 3'b000;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl: two instances (DWELL=4 and DWELL=1), each driving
// a behavioural 4:1 mux, checked against per-scan expectations derived from channel values.
module tb_mux_scan_ctrl;

    localparam int unsigned Dw0 = 4;
    localparam int unsigned Dw1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] continuous = '0;
    logic [1:0] snap_ready = '0;
    logic [1:0] mux_x;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] snap_valid;
    logic [1:0] busy;
    logic [3:0] snap [2];
    logic [3:0] chan [2];
    logic [3:0] prev [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mux_x[0] = chan[0][{s0[0], s1[0]}];
    assign mux_x[1] = chan[1][{s0[1], s1[1]}];

    mux_scan_ctrl #(.DWELL(Dw0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start[0]),
        .continuous (continuous[0]),
        .mux_x      (mux_x[0]),
        .s0         (s0[0]),
        .s1         (s1[0]),
        .snap       (snap[0]),
        .snap_valid (snap_valid[0]),
        .snap_ready (snap_ready[0]),
        .busy       (busy[0])
    );

    mux_scan_ctrl #(.DWELL(Dw1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start[1]),
        .continuous (continuous[1]),
        .mux_x      (mux_x[1]),
        .s0         (s0[1]),
        .s1         (s1[1]),
        .snap       (snap[1]),
        .snap_valid (snap_valid[1]),
        .snap_ready (snap_ready[1]),
        .busy       (busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dwell(input int i);
        return (i == 0) ? int'(Dw0) : int'(Dw1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check_eq($sformatf("%s_sel%0d", tag, i), 32'({s0[i], s1[i]}), 32'd0);
        check_eq($sformatf("%s_snap%0d", tag, i), 32'(snap[i]), 32'd0);
        check_eq($sformatf("%s_valid%0d", tag, i), 32'(snap_valid[i]), 32'd0);
        check_eq($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
    endtask

    // Sit in IDLE for some cycles, then pulse start; returns just after edge E0.
    task automatic start_scan(input int i, input int idle_cycles);
        start[i] = 1'b0;
        for (int n = 0; n < idle_cycles; n++) begin
            snap_ready[i] = 1'(($urandom));
            continuous[i] = 1'(($urandom));
            tick();
            check_eq($sformatf("idle_busy%0d", i), 32'(busy[i]), 32'd0);
            check_eq($sformatf("idle_valid%0d", i), 32'(snap_valid[i]), 32'd0);
            check_eq($sformatf("idle_snap%0d", i), 32'(snap[i]), 32'(prev[i]));
        end
        start[i] = 1'b1;
        snap_ready[i] = 1'b0;
        tick();
    endtask

    // Called just after E0: channel k/DWELL is presented during cycle k; already-sampled
    // channels are scrambled, and start/ready/continuous are randomized as noise.
    task automatic scan_body(input int i, input logic [3:0] chans);
        int d;
        d = dwell(i);
        chan[i] = chans;
        for (int k = 0; k < 4 * d; k++) begin
            check_eq($sformatf("scan_sel%0d_k%0d", i, k), 32'({s0[i], s1[i]}), 32'(k / d));
            check_eq($sformatf("scan_valid%0d", i), 32'(snap_valid[i]), 32'd0);
            check_eq($sformatf("scan_busy%0d", i), 32'(busy[i]), 32'd1);
            check_eq($sformatf("scan_snap_hold%0d", i), 32'(snap[i]), 32'(prev[i]));
            for (int j = 0; j < k / d; j++) chan[i][j] = 1'(($urandom));
            start[i]      = 1'(($urandom));
            snap_ready[i] = 1'(($urandom));
            continuous[i] = 1'(($urandom));
            tick();
        end
        check_eq($sformatf("done_valid%0d", i), 32'(snap_valid[i]), 32'd1);
        check_eq($sformatf("done_snap%0d", i), 32'(snap[i]), 32'(chans));
        check_eq($sformatf("done_sel%0d", i), 32'({s0[i], s1[i]}), 32'd0);
        check_eq($sformatf("done_busy%0d", i), 32'(busy[i]), 32'd1);
        prev[i] = chans;
    endtask

    task automatic done_phase(input int i, input int hold, input logic cont);
        for (int h = 0; h < hold; h++) begin
            snap_ready[i] = 1'b0;
            continuous[i] = 1'(($urandom));
            start[i]      = 1'(($urandom));
            chan[i]       = 4'(($urandom));
            tick();
            check_eq($sformatf("hold_valid%0d", i), 32'(snap_valid[i]), 32'd1);
            check_eq($sformatf("hold_snap%0d", i), 32'(snap[i]), 32'(prev[i]));
            check_eq($sformatf("hold_sel%0d", i), 32'({s0[i], s1[i]}), 32'd0);
            check_eq($sformatf("hold_busy%0d", i), 32'(busy[i]), 32'd1);
        end
        snap_ready[i] = 1'b1;
        continuous[i] = cont;
        tick();
        snap_ready[i] = 1'b0;
        check_eq($sformatf("hs_valid%0d", i), 32'(snap_valid[i]), 32'd0);
        check_eq($sformatf("hs_busy%0d", i), 32'(busy[i]), 32'(cont));
        check_eq($sformatf("hs_snap%0d", i), 32'(snap[i]), 32'(prev[i]));
        check_eq($sformatf("hs_sel%0d", i), 32'({s0[i], s1[i]}), 32'd0);
    endtask

    // Abort a scan while channel 2 is selected; reset must clear outputs asynchronously.
    task automatic reset_mid(input int i);
        start_scan(i, 1);
        start[i] = 1'b0;
        chan[i] = 4'(($urandom));
        for (int k = 0; k < 2 * dwell(i); k++) tick();
        check_eq($sformatf("pre_rst_sel%0d", i), 32'({s0[i], s1[i]}), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "rst_mid");
        check_reset_outputs(1, "rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        prev[0] = 4'b0000;
        prev[1] = 4'b0000;
        tick();
        check_reset_outputs(i, "post_rst");
    endtask

    initial begin
        logic       in_scan;
        logic       cont;
        logic [3:0] c;

        chan[0] = 4'b0000;
        chan[1] = 4'b0000;
        prev[0] = 4'b0000;
        prev[1] = 4'b0000;
        #3;
        check_reset_outputs(0, "reset");
        check_reset_outputs(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            // Directed: a..d = 1,0,1,1 (DWELL=4) or 0,1,0,1 (DWELL=1), long DONE hold.
            c = (i == 0) ? 4'b1101 : 4'b1010;
            start_scan(i, 2);
            scan_body(i, c);
            done_phase(i, 10, 1'b0);

            // Back-to-back continuous scans with ready high.
            start_scan(i, 1);
            scan_body(i, 4'b0011);
            done_phase(i, 0, 1'b1);
            scan_body(i, 4'b0011);
            done_phase(i, 0, 1'b1);
            scan_body(i, 4'b0011);
            done_phase(i, 0, 1'b0);

            // start held high straight into the next IDLE visit.
            start_scan(i, 0);
            scan_body(i, 4'(($urandom)));
            done_phase(i, 3, 1'b0);

            in_scan = 1'b0;
            for (int n = 0; n < 8; n++) begin
                c = 4'(($urandom));
                if (!in_scan) start_scan(i, $urandom_range(0, 3));
                scan_body(i, c);
                cont = 1'(($urandom));
                done_phase(i, $urandom_range(0, 4), cont);
                in_scan = cont;
            end
            if (in_scan) begin
                scan_body(i, 4'(($urandom)));
                done_phase(i, 1, 1'b0);
            end

            reset_mid(i);
            start_scan(i, 1);
            scan_body(i, 4'(($urandom)));
            done_phase(i, 2, 1'b0);
            start[i] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
